// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. It absorbs decode stalls and
// drops every in-flight entry on an exception request or a control flush.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Req,
  input  logic                     flush,
  input  logic                     F_valid,
  input  logic [31:0]              F_PC,
  input  logic [31:0]              F_Instr,
  input  logic                     F_AdEL,
  input  logic                     F_BD,
  output logic                     F_ready,
  input  logic                     D_ready,
  output logic                     D_valid,
  output logic [31:0]              D_PC,
  output logic [31:0]              D_Instr,
  output logic [4:0]               D_ExcCode,
  output logic                     D_BD,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic        bd;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;
  entry_t        head;

  // Ready and valid depend only on occupancy, so there is no D_ready -> F_ready path.
  assign F_ready = (count_q != C_FULL);
  assign D_valid = (count_q != '0);
  assign enq     = F_valid && F_ready;
  assign deq     = D_valid && D_ready;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (Req || flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[wp_q] = '{pc: F_PC, instr: F_Instr, adel: F_AdEL, bd: F_BD};
        wp_d        = wp_q + P_ONE;
      end
      if (deq) rp_d = rp_q + P_ONE;
      case ({enq, deq})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // An AdEL head keeps its PC for EPC but is presented as a nop.
  always_comb begin
    head      = mem_q[rp_q];
    D_PC      = '0;
    D_Instr   = '0;
    D_ExcCode = '0;
    D_BD      = 1'b0;
    if (D_valid) begin
      D_PC      = head.pc;
      D_Instr   = head.adel ? 32'd0 : head.instr;
      D_ExcCode = head.adel ? 5'd4 : 5'd0;
      D_BD      = head.bd;
    end
  end

  assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue with a scoreboard of expected head entries.
module tb_fetch_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1, Req = 1'b0, flush = 1'b0, F_valid = 1'b0;
  logic [31:0] F_PC = '0, F_Instr = '0;
  logic        F_AdEL = 1'b0, F_BD = 1'b0, D_ready = 1'b0;
  logic        F_ready, D_valid, D_BD;
  logic [31:0] D_PC, D_Instr;
  logic [4:0]  D_ExcCode;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Req(Req), .flush(flush),
    .F_valid(F_valid), .F_PC(F_PC), .F_Instr(F_Instr), .F_AdEL(F_AdEL), .F_BD(F_BD),
    .F_ready(F_ready), .D_ready(D_ready), .D_valid(D_valid), .D_PC(D_PC),
    .D_Instr(D_Instr), .D_ExcCode(D_ExcCode), .D_BD(D_BD), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, req, fl, fv;
    logic [31:0] pc, instr;
    logic        adel, bd, dr;
    int          e_cnt;
    logic        e_frdy, e_dval;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
    logic        adel, bd;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(logic rst, logic req, logic fl, logic fv, logic [31:0] pc,
                              logic [31:0] instr, logic adel, logic bd, logic dr,
                              int e_cnt, logic e_frdy, logic e_dval);
    vec_t v;
    v.rst = rst; v.req = req; v.fl = fl; v.fv = fv; v.pc = pc; v.instr = instr;
    v.adel = adel; v.bd = bd; v.dr = dr; v.e_cnt = e_cnt; v.e_frdy = e_frdy; v.e_dval = e_dval;
    return v;
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input bit chk);
    logic [70:0] exp_head;
    bit          full;
    ent_t        e;
    reset = v.rst; Req = v.req; flush = v.fl; F_valid = v.fv; F_PC = v.pc;
    F_Instr = v.instr; F_AdEL = v.adel; F_BD = v.bd; D_ready = v.dr;
    #2;
    exp_head = '0;
    if (sb.size() > 0) begin
      e = sb[0];
      exp_head = {1'b1, e.pc, e.adel ? 32'd0 : e.instr, e.adel ? 5'd4 : 5'd0, e.bd};
    end
    check("head", {D_valid, D_PC, D_Instr, D_ExcCode, D_BD}, exp_head);
    full = (sb.size() == DEPTH);
    if (v.rst || v.req || v.fl) sb.delete();
    else begin
      if (v.dr && sb.size() > 0) void'(sb.pop_front());
      if (v.fv && !full) begin
        e.pc = v.pc; e.instr = v.instr; e.adel = v.adel; e.bd = v.bd;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    check("count_model", 71'(count), 71'(sb.size()));
    if (chk) begin
      check("count", 71'(count), 71'(v.e_cnt));
      check("f_ready", 71'(F_ready), 71'(v.e_frdy));
      check("d_valid", 71'(D_valid), 71'(v.e_dval));
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    // rst req fl fv pc instr adel bd dr | cnt frdy dval
    tbl.push_back(mk(1,0,0,0, 32'h0,    32'h0,        0,0,0, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h3000, 32'h24010001, 0,0,0, 1,1,1));
    tbl.push_back(mk(0,0,0,1, 32'h3004, 32'h24020002, 0,0,0, 2,0,1));
    tbl.push_back(mk(0,0,0,1, 32'h3008, 32'h24030003, 0,0,0, 2,0,1));
    tbl.push_back(mk(0,0,0,1, 32'h300C, 32'h24040004, 0,0,1, 1,1,1));
    tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,        0,0,1, 0,1,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,0,1, 32'h3000 + 32'(4*i), 32'h24000000 + 32'(i), 0,0,1, 1,1,1));
    tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,        0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h2FFC, 32'h8C010000, 1,0,0, 1,1,1));
    tbl.push_back(mk(0,0,0,1, 32'h3010, 32'h24030003, 0,0,1, 1,1,1));
    tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,        0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h3000, 32'h24010001, 0,0,0, 1,1,1));
    tbl.push_back(mk(0,0,0,1, 32'h3004, 32'h24020002, 0,0,0, 2,0,1));
    tbl.push_back(mk(0,1,0,1, 32'h3008, 32'h24030003, 0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h4180, 32'h40806000, 0,0,0, 1,1,1));
    tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,        0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h3020, 32'h24050005, 0,1,0, 1,1,1));
    tbl.push_back(mk(0,0,0,1, 32'h3024, 32'h24060006, 0,0,0, 2,0,1));
    tbl.push_back(mk(0,0,1,1, 32'h3028, 32'h24070007, 0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h3030, 32'h24080008, 0,1,0, 1,1,1));
    tbl.push_back(mk(1,1,0,1, 32'h3034, 32'h24090009, 0,0,0, 0,1,0));
    tbl.push_back(mk(0,1,0,1, 32'h3038, 32'h240A000A, 0,0,0, 0,1,0));
    tbl.push_back(mk(0,1,0,1, 32'h303C, 32'h240B000B, 0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,0,1, 32'h3040, 32'h240C000C, 0,1,1, 1,1,1));
    tbl.push_back(mk(0,0,0,1, 32'h3044, 32'h240D000D, 1,0,0, 2,0,1));
    tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,        0,0,1, 1,1,1));
    tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,        0,0,1, 0,1,0));

    // Initial reset before any state is defined.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

    // Random traffic with occasional flushes, checked only against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      v = mk(0, ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
             1'($urandom_range(0, 3) != 0), 32'h5000 + 32'(4*i), $urandom,
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0), 0, 1'b0, 1'b0);
      step(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
